// File: rtl/fetch_stage_pkg.sv
// pipe_defs: encodings and constants shared by the fetch stage, the D-stage controller and the hazard unit.
package pipe_defs;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Branch displacement in bytes: sign-extended word offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage_npc_unit.sv
// npc_unit: combinational next-PC selection driven by the instruction currently in D.
module npc_unit
  import pipe_defs::*;
(
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc4_d,
  input  logic [31:0] ir_d,
  input  logic [31:0] rs_val_d,
  output logic [31:0] pc_f_plus4,
  output logic [31:0] npc
);

  assign pc_f_plus4 = pc_f + 32'd4;

  always_comb begin
    npc = pc_f_plus4;
    case (npc_sel)
      NPC_BR: begin
        // Targets are relative to the delay slot, i.e. PC_D+4.
        if (br_taken) begin
          npc = pc4_d + branch_offset(ir_d[15:0]);
        end
      end
      NPC_J:   npc = {pc_d[31:28], ir_d[25:0], 2'b00};
      NPC_JR:  npc = rs_val_d;
      default: npc = pc_f_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem fetch FSM and F/D pipeline register.
// Optional macro PC_ALIGN_CHECK_EN forces word-aligned redirects and flags misalignment.
module fetch_stage
  import pipe_defs::*;
#(
  parameter logic [31:0] PC_RESET = pipe_defs::PC_RESET,
  parameter logic [31:0] NOP_WORD = pipe_defs::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_val_D,
  fetch_stage_if.master imem,
  output logic        fetch_busy,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
`ifdef PC_ALIGN_CHECK_EN
  output logic [31:0] PC4_D,
  output logic        misalign_F
`else
  output logic [31:0] PC4_D
`endif
);

  fetch_state_e state_reg;
  logic [31:0]  pc_f_reg;
  logic [31:0]  ir_d_reg;
  logic [31:0]  pc_d_reg;
  logic [31:0]  pc4_d_reg;
  logic [31:0]  hold_reg;
  logic         hold_valid_reg;
  logic         busy_reg;

  logic [31:0]  pc_f_plus4;
  logic [31:0]  npc;
  logic [31:0]  pc_next;
  logic [31:0]  load_word;
  logic         do_load;

  npc_unit u_npc (
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .pc_f       (pc_f_reg),
    .pc_d       (pc_d_reg),
    .pc4_d      (pc4_d_reg),
    .ir_d       (ir_d_reg),
    .rs_val_d   (rs_val_D),
    .pc_f_plus4 (pc_f_plus4),
    .npc        (npc)
  );

  // A word parked during a stalled WAIT completes the next un-stalled load
  // without waiting on imem again.
  always_comb begin
    do_load   = 1'b0;
    load_word = imem.imem_rdata;
    case (state_reg)
      ST_RUN: begin
        if (hold_valid_reg) begin
          do_load   = ~stall;
          load_word = hold_reg;
        end else begin
          do_load = imem.imem_ready & ~stall;
        end
      end
      ST_WAIT: do_load = imem.imem_ready & ~stall;
      default: do_load = 1'b0;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_reg;
  logic [31:0] badpc_reg;

  assign pc_next    = {npc[31:2], 2'b00};
  assign misalign_F = misalign_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_reg <= 1'b0;
      badpc_reg    <= 32'd0;
    end else if (do_load && npc[1:0] != 2'b00) begin
      misalign_reg <= 1'b1;
      if (!misalign_reg) begin
        badpc_reg <= npc;
      end
    end
  end
`else
  assign pc_next = npc;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_RUN;
      busy_reg       <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_reg       <= NOP_WORD;
      pc_f_reg       <= PC_RESET;
      ir_d_reg       <= NOP_WORD;
      pc_d_reg       <= 32'd0;
      pc4_d_reg      <= 32'd0;
    end else begin
      if (do_load) begin
        pc_f_reg  <= pc_next;
        ir_d_reg  <= load_word;
        pc_d_reg  <= pc_f_reg;
        pc4_d_reg <= pc_f_plus4;
      end
      case (state_reg)
        ST_RUN: begin
          if (hold_valid_reg) begin
            if (!stall) begin
              hold_valid_reg <= 1'b0;
            end
          end else if (!imem.imem_ready) begin
            state_reg <= ST_WAIT;
            busy_reg  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem.imem_ready) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
            if (stall) begin
              hold_reg       <= imem.imem_rdata;
              hold_valid_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_RUN;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Both states request; the request only drops while reset is asserted.
  assign imem.imem_req  = reset;
  assign imem.imem_addr = pc_f_reg;
  assign fetch_busy     = busy_reg;
  assign IR_D           = ir_d_reg;
  assign PC_D           = pc_d_reg;
  assign PC4_D          = pc4_d_reg;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory request, and the F/D pipeline register that produces IR_D and PC4_D.
- Sits directly upstream of the hazard/forwarding logic. Consumes its stall output and the D-stage branch decision. Feeds IR_D to the D-stage decoder and to the hazard unit.
- One branch delay slot is architectural. There is no flush on taken branches.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset (first fetch address).
- NOP_WORD, 32'h0000_0000, bubble word loaded into IR_D after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the clk rising edge, reset when 0.
- stall  in  1  hazard-unit stall; freezes PC and F/D register.
- npc_sel  in  2  next-PC source for the instruction in D: 00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr.
- br_taken  in  1  D-stage compare result; qualifies npc_sel=01.
- rs_val_D  in  32  forwarded rs value in D (jr target).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= pc_F).
- imem_rdata  in  32  instruction word.
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr.
- fetch_busy  out  1  fetch outstanding; OR'd into the global stall externally.
- IR_D  out  32  instruction in D.
- PC_D  out  32  PC of the instruction in D.
- PC4_D  out  32  PC_D+4.

Behaviour:
- Reset, on a clk edge with reset=0:
  - pc_F=PC_RESET; IR_D=NOP_WORD; PC_D=0; PC4_D=0.
  - state=RUN; imem_req=0 during the reset cycle.
  - Reset overrides stall, a pending WAIT, and a redirect.
- Next-PC computation (combinational, from D-stage fields):
  - npc = pc_F+4, except:
  - npc_sel=01 with br_taken=1: npc = PC4_D + (sign-extended IR_D[15:0] << 2).
  - npc_sel=01 with br_taken=0: npc = pc_F+4.
  - npc_sel=10: npc = {PC_D[31:28], IR_D[25:0], 2'b00}.
  - npc_sel=11: npc = rs_val_D.
  - All arithmetic is 32-bit, modulo 2^32; no overflow detection.
- The redirect applies to pc_F, not to the instruction already in F, which is the delay slot. That instruction always enters D.
- FSM states:
  - RUN: imem_req=1, fetch_busy=0.
    - imem_ready=1 and stall=0: pc_F<=npc; IR_D<=imem_rdata; PC_D<=pc_F; PC4_D<=pc_F+4.
    - imem_ready=1 and stall=1: everything holds; the data is re-fetched next cycle (imem is read-idempotent).
    - imem_ready=0: go to WAIT; pc_F and F/D hold.
  - WAIT: imem_req=1, imem_addr=pc_F held stable, fetch_busy=1.
    - imem_ready=1 and stall=0: perform the RUN load, go to RUN.
    - imem_ready=1 and stall=1: capture imem_rdata into a holding register (hold_valid=1), go to RUN. While hold_valid=1, the next un-stalled load takes IR_D from the holding register and clears hold_valid.
    - imem_ready=0: stay in WAIT.
- Stall semantics: when stall=1, IR_D, PC_D, PC4_D and pc_F do not change. The D-stage instruction and the redirect stay stable because IR_D is frozen.
- Simultaneous stall=1 and a redirect: the redirect is ignored that cycle and re-evaluated after the stall releases, with identical IR_D.
- Wrap-around: pc_F=32'hFFFF_FFFC with sequential fetch gives npc=0.
- Misaligned targets (low 2 bits != 0) pass through unchanged unless PC_ALIGN_CHECK_EN is defined.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_F (1 bit) and register badpc (32 bit).
  - When a redirect would load an npc with npc[1:0]!=0: pc_F <= {npc[31:2], 2'b00}, misalign_F <= 1 (sticky until reset), and badpc captures the raw npc (first event only).
- Not defined: the ports are absent and npc is loaded unmodified.

Decomposition:
- Shared package pipe_defs:
  - NPC_* encodings (NPC_PC4=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11).
  - PC_RESET and NOP_WORD constants.
  - Shared with the D-stage controller and the hazard unit.
- Sub-module npc_unit: pure combinational next-PC mux and adders.
- The fetch FSM and the F/D register stay in fetch_stage.

Test Plan:
- Reset then imem_ready=1 every cycle, no stall -> imem_addr sequence 0x3000, 0x3004, 0x3008; IR_D=0 until the first load; PC_D=0x3000 one cycle after reset release.
- beq in D at PC_D=0x3004, imm16=0xFFFF, br_taken=1, npc_sel=01 -> delay slot 0x3008 enters D; next imem_addr=0x3004.
- jr with rs_val_D=0x3040, npc_sel=11 asserted together with stall=1 for 2 cycles -> pc_F, IR_D, PC_D hold both cycles; pc_F=0x3040 one cycle after stall drops.
- imem_ready=0 for 3 cycles at 0x300C -> fetch_busy=1 and imem_addr=0x300C stable for 3 cycles; IR_D updates on the ready cycle.
- Ready arrives while stall=1 in WAIT -> word held internally; on stall release IR_D gets the held word with no extra imem cycle.
- reset=0 asserted during WAIT with a redirect pending -> pc_F=0x3000, IR_D=0, fetch_busy=0 next cycle.
